had_bkpt_ctrl: RTL and testbench

Breakpoint trigger controller in the HAD debug path, directly downstream of the two per-comparator breakpoint match units (A and B). Turns their single-cycle instruction/data match strobes into one debug-mode request to the core, applying a programmable combine mode (A only, A or B, A-then-B sequence) and an optional pass counter. It holds the request until the core reports debug entry, then stays quiet until debug exit. It also records the hit reason and sticky hit status for the register file.

---
 rtl/had_bkpt_ctrl.sv | 99 +++++++++
 tb/tb_had_bkpt_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/had_bkpt_ctrl.sv
// had_bkpt_ctrl: combines breakpoint A/B match strobes into one held debug-mode request to the core.
// Combine modes: off, A only, A or B, A then B. Each hit sets a sticky flag, and the reason for the last request is recorded.
// Defining HAD_BKPT_CNT_EN builds a pass counter. Without it every fire triggers and bc_cnt_cur reads 0.
module had_bkpt_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 cpuclk,
  input  logic                 hadrst_b,
  input  logic                 regs_bc_en,
  input  logic [1:0]           regs_bc_mode,
  input  logic                 regs_cnt_ld,
  input  logic [CNT_WIDTH-1:0] regs_cnt_val,
  input  logic                 regs_hit_clr,
  input  logic                 bkpta_inst_match,
  input  logic                 bkpta_data_match,
  input  logic                 bkptb_inst_match,
  input  logic                 bkptb_data_match,
  input  logic                 iu_yy_xx_dbgon,
  output logic                 bc_core_dbg_mode_req,
  output logic [2:0]           bc_dbg_reason,
  output logic [1:0]           bc_hit_sticky,
  output logic [CNT_WIDTH-1:0] bc_cnt_cur
);
  typedef enum logic [1:0] {IDLE, SEQ_WAIT, REQ, DEBUG} state_t;
  state_t state_q, state_d;
  logic       req_q, req_d;
  logic [2:0] rsn_q, rsn_d;
  logic [1:0] sticky_q, sticky_d;
  logic [1:0] mode_q, mode_d;
  logic       gate, hit_a, hit_b, abort, seq_start, fire, cnt_zero, trig, dec;
  logic [2:0] rsn_fire;
  assign gate      = iu_yy_xx_dbgon | ~regs_bc_en | (regs_bc_mode == 2'b00);
  assign hit_a     = (bkpta_inst_match | bkpta_data_match) & ~gate;
  assign hit_b     = (bkptb_inst_match | bkptb_data_match) & ~gate;
  assign abort     = ~regs_bc_en | (regs_bc_mode != mode_q);
  assign seq_start = (state_q == IDLE) & (regs_bc_mode == 2'b11) & hit_a & ~hit_b;
  assign trig      = fire & cnt_zero;
  assign dec       = fire & ~cnt_zero;
  // Qualify a fire for the current state and mode, and work out the reason it would report.
  always_comb begin
    fire = (state_q == SEQ_WAIT) ? hit_b & ~abort :
           (state_q != IDLE)     ? 1'b0 :
           (regs_bc_mode == 2'b01) ? hit_a :
           (regs_bc_mode == 2'b10) ? hit_a | hit_b :
           (regs_bc_mode == 2'b11) ? hit_a & hit_b : 1'b0;
    rsn_fire = (state_q == SEQ_WAIT)  ? 3'b100 :
               (regs_bc_mode == 2'b01) ? 3'b001 :
               (hit_a & hit_b)         ? 3'b011 :
               hit_a                   ? 3'b001 : 3'b010;
  end
  // Next state, registered request and reason latch, sticky hit flags.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = trig ? REQ : seq_start ? SEQ_WAIT : IDLE;
      SEQ_WAIT: state_d = abort ? IDLE : fire ? (trig ? REQ : IDLE) : SEQ_WAIT;
      REQ:      state_d = abort ? IDLE : iu_yy_xx_dbgon ? DEBUG : REQ;
      DEBUG:    state_d = iu_yy_xx_dbgon ? DEBUG : IDLE;
      default:  state_d = IDLE;
    endcase
    req_d    = state_d == REQ;
    rsn_d    = trig ? rsn_fire : rsn_q;
    sticky_d = (regs_hit_clr ? 2'b00 : sticky_q) | {hit_b, hit_a};
    mode_d   = regs_bc_mode;
  end
  // Trigger FSM and its registered outputs.
  always_ff @(posedge cpuclk) begin
    if (!hadrst_b) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      rsn_q    <= 3'b000;
      sticky_q <= 2'b00;
      mode_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rsn_q    <= rsn_d;
      sticky_q <= sticky_d;
      mode_q   <= mode_d;
    end
  end
`ifdef HAD_BKPT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  // A load beats a decrement. Only a fire that does not trigger decrements, so the count stops at 0.
  always_comb cnt_d = regs_cnt_ld ? regs_cnt_val : dec ? cnt_q - CNT_WIDTH'(1) : cnt_q;
  // Pass counter register.
  always_ff @(posedge cpuclk) cnt_q <= !hadrst_b ? '0 : cnt_d;
  assign cnt_zero   = cnt_q == '0;
  assign bc_cnt_cur = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{regs_cnt_ld, regs_cnt_val, dec};
  assign cnt_zero   = 1'b1;
  assign bc_cnt_cur = '0;
`endif
  assign bc_core_dbg_mode_req = req_q;
  assign bc_dbg_reason        = rsn_q;
  assign bc_hit_sticky        = sticky_q;
endmodule

// File: tb/tb_had_bkpt_ctrl.sv
// tb_had_bkpt_ctrl: scoreboard bench for the breakpoint trigger controller.
module tb_had_bkpt_ctrl;
  logic cpuclk = 1'b0, hadrst_b, regs_bc_en, regs_cnt_ld, regs_hit_clr, iu_yy_xx_dbgon;
  logic bkpta_inst_match, bkpta_data_match, bkptb_inst_match, bkptb_data_match;
  logic [1:0] regs_bc_mode;
  logic [15:0] regs_cnt_val;
  logic req;
  logic [2:0] rsn;
  logic [1:0] sticky;
  logic [15:0] cnt;
  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic rb, en;
    logic [1:0] mode;
    logic ai, ad, bi, bd, dbg, clr, ld;
    logic [15:0] val;
  } stim_t;
  typedef struct packed {
    logic req;
    logic [2:0] rsn;
    logic [1:0] sticky;
    logic [15:0] cnt;
  } obs_t;
  obs_t exp_q[$];

  had_bkpt_ctrl #(.CNT_WIDTH(16)) dut (
    .cpuclk(cpuclk), .hadrst_b(hadrst_b), .regs_bc_en(regs_bc_en), .regs_bc_mode(regs_bc_mode),
    .regs_cnt_ld(regs_cnt_ld), .regs_cnt_val(regs_cnt_val), .regs_hit_clr(regs_hit_clr),
    .bkpta_inst_match(bkpta_inst_match), .bkpta_data_match(bkpta_data_match),
    .bkptb_inst_match(bkptb_inst_match), .bkptb_data_match(bkptb_data_match),
    .iu_yy_xx_dbgon(iu_yy_xx_dbgon), .bc_core_dbg_mode_req(req), .bc_dbg_reason(rsn),
    .bc_hit_sticky(sticky), .bc_cnt_cur(cnt)
  );

  always #5 cpuclk = ~cpuclk;

  function automatic stim_t S(int rb, int en, int md, int ai, int ad, int bi, int bd, int dbg, int clr, int ld, int val);
    stim_t s;
    s.rb = rb[0]; s.en = en[0]; s.mode = md[1:0]; s.ai = ai[0]; s.ad = ad[0]; s.bi = bi[0];
    s.bd = bd[0]; s.dbg = dbg[0]; s.clr = clr[0]; s.ld = ld[0]; s.val = val[15:0];
    return s;
  endfunction

  function automatic obs_t E(int rq, int rs, int st, int c);
    obs_t o;
    o.req = rq[0]; o.rsn = rs[2:0]; o.sticky = st[1:0]; o.cnt = c[15:0];
    return o;
  endfunction

  task automatic drive(input stim_t s);
    hadrst_b = s.rb; regs_bc_en = s.en; regs_bc_mode = s.mode;
    bkpta_inst_match = s.ai; bkpta_data_match = s.ad; bkptb_inst_match = s.bi; bkptb_data_match = s.bd;
    iu_yy_xx_dbgon = s.dbg; regs_hit_clr = s.clr; regs_cnt_ld = s.ld; regs_cnt_val = s.val;
  endtask

  task automatic tick();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0));
    st.push_back(S(0,1,1,1,1,1,1,0,0,1,9)); ex.push_back(E(0,0,0,0));
    foreach (st[i]) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      got = {req, rsn, sticky, cnt}; want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got req=%b rsn=%b sticky=%b cnt=%0d, want req=%b rsn=%b sticky=%b cnt=%0d",
                 i, got.req, got.rsn, got.sticky, got.cnt, want.req, want.rsn, want.sticky, want.cnt);
      end
    end
  endtask

  task automatic test_mode_a();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1,1,1,0,1,0,0,0,0,0,0)); ex.push_back(E(1,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(1,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,1,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,1,1,0,1,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(1,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,1,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,1,0,0)); ex.push_back(E(0,1,0,0));
    foreach (st[i]) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      got = {req, rsn, sticky, cnt}; want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mode_a[%0d]: got req=%b rsn=%b sticky=%b cnt=%0d, want req=%b rsn=%b sticky=%b cnt=%0d",
                 i, got.req, got.rsn, got.sticky, got.cnt, want.req, want.rsn, want.sticky, want.cnt);
      end
    end
  endtask

  task automatic test_seq();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1,1,3,0,0,1,0,0,0,0,0)); ex.push_back(E(0,1,2,0));
    st.push_back(S(1,1,3,1,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,3,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,3,0,1,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,3,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,3,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,3,0,0,0,1,0,0,0,0)); ex.push_back(E(1,4,3,0));
    st.push_back(S(1,1,3,0,0,0,0,1,0,0,0)); ex.push_back(E(0,4,3,0));
    st.push_back(S(1,1,3,0,0,0,0,0,0,0,0)); ex.push_back(E(0,4,3,0));
    st.push_back(S(1,1,3,1,0,1,0,0,0,0,0)); ex.push_back(E(1,3,3,0));
    st.push_back(S(1,1,3,0,0,0,0,1,0,0,0)); ex.push_back(E(0,3,3,0));
    st.push_back(S(1,1,3,0,0,0,0,0,1,0,0)); ex.push_back(E(0,3,0,0));
    st.push_back(S(1,1,3,1,0,0,0,0,0,0,0)); ex.push_back(E(0,3,1,0));
    st.push_back(S(1,0,3,0,0,0,0,0,0,0,0)); ex.push_back(E(0,3,1,0));
    st.push_back(S(1,1,3,0,0,1,0,0,0,0,0)); ex.push_back(E(0,3,3,0));
    st.push_back(S(1,1,3,0,0,0,0,0,1,0,0)); ex.push_back(E(0,3,0,0));
    foreach (st[i]) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      got = {req, rsn, sticky, cnt}; want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL seq[%0d]: got req=%b rsn=%b sticky=%b cnt=%0d, want req=%b rsn=%b sticky=%b cnt=%0d",
                 i, got.req, got.rsn, got.sticky, got.cnt, want.req, want.rsn, want.sticky, want.cnt);
      end
    end
  endtask

  task automatic test_mode_or();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1,1,2,1,0,1,0,0,0,0,0)); ex.push_back(E(1,3,3,0));
    st.push_back(S(1,1,2,0,0,0,0,1,0,0,0)); ex.push_back(E(0,3,3,0));
    st.push_back(S(1,1,2,0,0,0,0,0,0,0,0)); ex.push_back(E(0,3,3,0));
    st.push_back(S(1,1,2,1,0,0,0,0,1,0,0)); ex.push_back(E(1,1,1,0));
    st.push_back(S(1,1,2,0,0,0,0,1,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,2,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,2,0,0,0,1,0,0,0,0)); ex.push_back(E(1,2,3,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,2,3,0));
    st.push_back(S(1,1,1,0,1,0,0,0,0,0,0)); ex.push_back(E(1,1,3,0));
    st.push_back(S(1,1,1,0,0,0,0,1,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,1,0,0,0,0,0,1,0,0)); ex.push_back(E(0,1,0,0));
    foreach (st[i]) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      got = {req, rsn, sticky, cnt}; want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mode_or[%0d]: got req=%b rsn=%b sticky=%b cnt=%0d, want req=%b rsn=%b sticky=%b cnt=%0d",
                 i, got.req, got.rsn, got.sticky, got.cnt, want.req, want.rsn, want.sticky, want.cnt);
      end
    end
  endtask

  task automatic test_gating();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1,1,1,1,0,1,0,1,0,0,0)); ex.push_back(E(0,1,0,0));
    st.push_back(S(1,0,1,1,0,0,1,0,0,0,0)); ex.push_back(E(0,1,0,0));
    st.push_back(S(1,1,0,0,1,1,0,0,0,0,0)); ex.push_back(E(0,1,0,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,0,0));
    st.push_back(S(1,1,1,0,0,1,0,0,0,0,0)); ex.push_back(E(0,1,2,0));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(1,1,3,0));
    st.push_back(S(1,0,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(1,1,3,0));
    st.push_back(S(1,1,1,0,0,0,0,1,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,3,0));
    st.push_back(S(1,1,1,0,0,0,0,0,1,0,0)); ex.push_back(E(0,1,0,0));
    foreach (st[i]) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      got = {req, rsn, sticky, cnt}; want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL gating[%0d]: got req=%b rsn=%b sticky=%b cnt=%0d, want req=%b rsn=%b sticky=%b cnt=%0d",
                 i, got.req, got.rsn, got.sticky, got.cnt, want.req, want.rsn, want.sticky, want.cnt);
      end
    end
  endtask

  task automatic test_counter();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
`ifdef HAD_BKPT_CNT_EN
    st.push_back(S(1,1,1,0,0,0,0,0,0,1,3)); ex.push_back(E(0,1,0,3));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,2));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,1));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(1,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,1,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,1,5)); ex.push_back(E(0,1,1,5));
    st.push_back(S(1,1,1,1,0,0,0,0,0,1,7)); ex.push_back(E(0,1,1,7));
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,6));
    st.push_back(S(1,1,3,1,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,6));
    st.push_back(S(1,1,3,0,0,1,0,0,0,0,0)); ex.push_back(E(0,1,3,5));
    st.push_back(S(1,1,3,0,0,1,0,0,0,0,0)); ex.push_back(E(0,1,3,5));
    st.push_back(S(1,1,3,0,0,0,0,0,1,1,0)); ex.push_back(E(0,1,0,0));
`else
    st.push_back(S(1,1,1,1,0,0,0,0,0,1,3)); ex.push_back(E(1,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,1,0,0,0)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,0,1,4)); ex.push_back(E(0,1,1,0));
    st.push_back(S(1,1,1,0,0,0,0,0,1,0,0)); ex.push_back(E(0,1,0,0));
`endif
    foreach (st[i]) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      got = {req, rsn, sticky, cnt}; want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL counter[%0d]: got req=%b rsn=%b sticky=%b cnt=%0d, want req=%b rsn=%b sticky=%b cnt=%0d",
                 i, got.req, got.rsn, got.sticky, got.cnt, want.req, want.rsn, want.sticky, want.cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1,1,1,1,0,0,0,0,0,0,0)); ex.push_back(E(1,1,1,0));
    st.push_back(S(0,1,1,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0));
    st.push_back(S(1,1,3,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,1,0));
    st.push_back(S(0,1,3,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0));
    st.push_back(S(1,1,3,0,0,1,0,0,0,0,0)); ex.push_back(E(0,0,2,0));
    st.push_back(S(1,1,3,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,2,0));
    st.push_back(S(1,1,3,0,0,0,0,0,1,0,0)); ex.push_back(E(0,0,0,0));
    foreach (st[i]) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      got = {req, rsn, sticky, cnt}; want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got req=%b rsn=%b sticky=%b cnt=%0d, want req=%b rsn=%b sticky=%b cnt=%0d",
                 i, got.req, got.rsn, got.sticky, got.cnt, want.req, want.rsn, want.sticky, want.cnt);
      end
    end
  endtask

  initial begin
    drive(S(0,0,0,0,0,0,0,0,0,0,0));
    test_reset();
    test_mode_a();
    test_seq();
    test_mode_or();
    test_gating();
    test_counter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
